// File: rtl/cdr_oversample4_pkg.sv
// Shared definitions for the oversampling CDR receiver: FSM state encoding
// and the default ratio/limit values also used by clock_divider4 users.
package cdr_oversample4_pkg;

  typedef enum logic {
    CDR_HUNT   = 1'b0,
    CDR_LOCKED = 1'b1
  } cdr_state_e;

  localparam int CDR_OSR_DEF         = 4;
  localparam int CDR_SYNC_STAGES_DEF = 2;
  localparam int CDR_LOCK_EDGES_DEF  = 8;
  localparam int CDR_IDLE_LIMIT_DEF  = 16;

  // Counter width able to hold 0..max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/cdr_oversample4_if.sv
// Serial input and recovered outputs of the CDR receiver.
// master: the environment driving data_in; slave: the receiver itself.
interface cdr_oversample4_if;
  logic data_in;
  logic data_out;
  logic data_valid;
  logic clk_out;
  logic locked;

  modport master (
    output data_in,
    input  data_out,
    input  data_valid,
    input  clk_out,
    input  locked
  );

  modport slave (
    input  data_in,
    output data_out,
    output data_valid,
    output clk_out,
    output locked
  );
endinterface

// File: rtl/cdr_oversample4_bit_synchronizer.sv
// Multi-flop synchronizer bringing the asynchronous serial line into the
// clk_in domain.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  // Shift the raw input through the flop chain; reset clears every stage.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/cdr_oversample4.sv
// Oversampling clock/data recovery receiver. clk_in runs at OSR times the
// bit rate; a phase counter is re-centred on every data transition, the
// line is sampled mid-bit, and a bit-rate clock is produced that follows
// the data edges. A two-state FSM reports lock once enough consecutive
// edges fall within +/-1 clk_in of the expected position.
module cdr_oversample4
  import cdr_oversample4_pkg::*;
#(
  parameter int OSR         = CDR_OSR_DEF,
  parameter int SYNC_STAGES = CDR_SYNC_STAGES_DEF,
  parameter int LOCK_EDGES  = CDR_LOCK_EDGES_DEF,
  parameter int IDLE_LIMIT  = CDR_IDLE_LIMIT_DEF
) (
  input logic             clk_in,
  input logic             rst,
  cdr_oversample4_if.slave bus
);

  localparam int PH_W = cnt_w(OSR - 1);
  localparam int GC_W = cnt_w(LOCK_EDGES);
  localparam int IC_W = cnt_w(IDLE_LIMIT);

  localparam logic [PH_W-1:0] PH_ZERO = '0;
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OSR / 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

  localparam logic [GC_W-1:0] GOOD_MAX = GC_W'(LOCK_EDGES);
  localparam logic [IC_W-1:0] IDLE_MAX = IC_W'(IDLE_LIMIT);

  logic            sync_q;
  logic            sync_prev;
  logic            edge_det;
  logic [PH_W-1:0] ph;
  logic            good_edge;
  logic            sample;
  logic            wrap;
  logic            edge_seen;
  logic [IC_W-1:0] idle_cnt;
  logic [GC_W-1:0] good_cnt;
  logic [GC_W-1:0] good_cnt_nxt;
  cdr_state_e      state;
  cdr_state_e      state_nxt;

  logic            data_out_r;
  logic            data_valid_r;
  logic            clk_out_r;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (bus.data_in),
    .q      (sync_q)
  );

  // One-cycle delayed copy of the synchronized line for transition detection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_prev <= 1'b0;
    end else begin
      sync_prev <= sync_q;
    end
  end

  assign edge_det  = (sync_q != sync_prev);
  // An edge within one clk_in of the ideal position (ph==0) is acceptable.
  assign good_edge = (ph == PH_LAST) || (ph == PH_ZERO) || (ph == PH_ONE);
  // A colliding edge takes priority over the mid-bit sample.
  assign sample    = (ph == PH_MID) && !edge_det;
  assign wrap      = (ph == PH_LAST) && !edge_det;

  // Phase counter: free-running modulo OSR, re-centred so the edge cycle is phase 0.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      ph <= PH_ZERO;
    end else if (edge_det) begin
      ph <= PH_ONE;
    end else if (ph == PH_LAST) begin
      ph <= PH_ZERO;
    end else begin
      ph <= ph + PH_ONE;
    end
  end

  // Mid-bit sampler and recovered clock. The edge cycle is treated as phase 0,
  // so a re-aligning edge may end the clk_out high phase early; every level
  // still lasts at least one whole clk_in cycle because clk_out is registered.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      data_out_r   <= 1'b0;
      data_valid_r <= 1'b0;
      clk_out_r    <= 1'b0;
    end else begin
      data_valid_r <= sample;
      if (sample) begin
        data_out_r <= sync_q;
        clk_out_r  <= 1'b1;
      end else if (edge_det || (ph == PH_ZERO)) begin
        clk_out_r  <= 1'b0;
      end
    end
  end

  // Idle tracker: counts whole bit periods without a transition, saturating.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      edge_seen <= 1'b0;
      idle_cnt  <= '0;
    end else if (edge_det) begin
      edge_seen <= 1'b1;
      idle_cnt  <= '0;
    end else if (wrap) begin
      edge_seen <= 1'b0;
      if (!edge_seen && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + IC_W'(1);
      end
    end
  end

  // Lock FSM state and good-edge counter registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= CDR_HUNT;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  // Lock FSM next state: the first edge in HUNT is the alignment edge and
  // always counts; any later edge must be good or the count restarts.
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    case (state)
      CDR_HUNT: begin
        if (edge_det) begin
          if (good_edge || (good_cnt == '0)) begin
            if (good_cnt != GOOD_MAX) begin
              good_cnt_nxt = good_cnt + GC_W'(1);
            end
          end else begin
            good_cnt_nxt = '0;
          end
          if (good_cnt_nxt == GOOD_MAX) begin
            state_nxt = CDR_LOCKED;
          end
        end
      end
      CDR_LOCKED: begin
        if ((edge_det && !good_edge) || (idle_cnt == IDLE_MAX)) begin
          state_nxt    = CDR_HUNT;
          good_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = CDR_HUNT;
        good_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.clk_out    = clk_out_r;
  assign bus.locked     = (state == CDR_LOCKED);

endmodule
